draw_scheduler: RTL and testbench
=================================

Name: draw_scheduler

Overview:
- Frame-level draw sequencer between the sprite generators (dino character, obstacles, ground) and the VGA adapter.
- On each frame tick, grants `enable` to each sprite client in turn for a fixed slot of cycles.
- Muxes the granted client's pixel stream (x, y, colour) onto the single VGA write port and generates `plot`.
- Aligns the client's combinational x/y with its one-cycle-registered colour.

Parameters:
- NUM_CLIENTS, 3, number of sprite clients; client 0 has highest draw order (drawn first).
- SLOT_CYCLES, 128, enable-high cycles per client; must be a multiple of 128 so a client's 7-bit pixel counter wraps cleanly.
- FRAME_DIV, 833333, clock cycles per frame tick (50 MHz / 60 Hz).
- GAP_CYCLES, 2, idle cycles between consecutive client slots.

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- pause  in  1  when high, frame ticks do not start new frames
- client_enable  out  NUM_CLIENTS  one-hot grant; bit k drives client k's enable
- client_x  in  8*NUM_CLIENTS  client k's x on bits [8k+7:8k]; combinational from the client counter
- client_y  in  7*NUM_CLIENTS  client k's y on bits [7k+6:7k]
- client_colour  in  3*NUM_CLIENTS  client k's colour, registered one cycle after its x/y
- vga_x  out  8  pixel x to VGA adapter
- vga_y  out  7  pixel y
- vga_colour  out  3  pixel colour
- vga_plot  out  1  write strobe
- frame_busy  out  1  high while any slot or gap of the current frame is in progress
- frame_count  out  16  completed frames; wraps 65535->0
- overrun  out  1  sticky; a tick arrived while frame_busy

Behaviour:
- Reset (async, resetn low): every output and internal register is 0, including client_enable, vga_x, vga_y, vga_colour, vga_plot, frame_busy, frame_count, overrun, the tick divider, the state and the pipelines. Release is synchronous to the next clock edge.
- Tick divider: counts 0..FRAME_DIV-1 and wraps. `tick` is a one-cycle pulse when the count equals FRAME_DIV-1. The divider free-runs regardless of pause and state.
- States:
  - IDLE -> SLOT on tick && !pause && !frame_busy. Set idx=0 and slot_cnt=0.
  - SLOT: client_enable = (1<<idx), registered, so it is high on exactly SLOT_CYCLES consecutive cycles. slot_cnt increments each cycle.
  - SLOT -> GAP when slot_cnt == SLOT_CYCLES-1. client_enable goes to 0 on the next cycle.
  - GAP: all enables low for GAP_CYCLES cycles. Then, if idx < NUM_CLIENTS-1, set idx++ and go to SLOT; otherwise go to DONE.
  - DONE: frame_count++ and go to IDLE in one cycle.
- frame_busy is high in SLOT, GAP and DONE.
- Tick while frame_busy: tick is dropped (not queued) and overrun is set to 1. overrun clears only on reset.
- pause rising mid-frame: the current frame completes normally; only new frame starts are blocked.
- Datapath, 2-stage pipeline:
  - Stage 1 registers x, y, idx and en = |client_enable.
  - Stage 2 registers vga_x and vga_y from stage 1, and vga_plot from stage-1 en.
  - vga_colour is registered from client_colour selected by the stage-1 idx. Because client colour already lags its x/y by one cycle, vga_colour pairs with the matching x/y.
  - Net: vga_plot is high exactly SLOT_CYCLES cycles per client, starting 2 cycles after client_enable rises.
- Out-of-window data: when vga_plot is 0, vga_x/y/colour hold their last values. The VGA adapter must ignore them.
- Slot duration: the erase-then-draw sequence inside a client's slot is the client's business. The scheduler only guarantees contiguous enable for SLOT_CYCLES cycles.
- Reset mid-slot: enables drop asynchronously to 0 and the pipeline clears, so no plot is emitted. The next frame starts at client 0.
- Any client x/y arithmetic overflow passes through unmodified. No clipping.

Test Plan:
- Reset/idle: FRAME_DIV=1000. Hold resetn low 5 cycles, release, run 999 cycles -> all outputs 0 throughout; client_enable == 0.
- Full frame: FRAME_DIV=1000, 3 clients, SLOT_CYCLES=128, GAP_CYCLES=2. After tick:
  - enable bit0 high for 128 cycles, 2-cycle gap, then bit1 for 128, gap, then bit2 for 128.
  - frame_count 0->1 one cycle after the last gap.
  - frame_busy high for 3*128+3*2+1 = 391 cycles.
- Alignment: client1 model drives x=counter, y=counter+1 and colour registered from x[2:0] -> every vga_plot cycle has vga_colour == vga_x[2:0] and vga_y == vga_x+1. Exactly 128 plot cycles per client; none during gaps.
- Overrun: FRAME_DIV=300 with the 391-cycle frame -> the tick at cycle 300 (relative to first tick) is dropped and overrun=1. The next frame starts on the first tick with frame_busy low; frame_count increments once per completed frame.
- Pause: assert pause mid-slot of client1 -> the frame completes and frame_count increments. Subsequent ticks produce no enables while paused. Deassert -> the next tick starts a frame.
- Async reset mid-slot: pulse resetn low 1 cycle during client0's slot (not on a clock edge) -> client_enable and vga_plot go 0 immediately. frame_count=0; the next tick restarts at client 0.

Source files
------------

// File: rtl/draw_scheduler.sv
// Frame-level draw sequencer: on each frame tick, grants every sprite client a
// contiguous enable slot and muxes its pixel stream onto the VGA write port.
module draw_scheduler #(
  parameter int NUM_CLIENTS = 3,
  parameter int SLOT_CYCLES = 128,
  parameter int FRAME_DIV   = 833333,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     pause,
  output logic [NUM_CLIENTS-1:0]   client_enable,
  input  logic [8*NUM_CLIENTS-1:0] client_x,
  input  logic [7*NUM_CLIENTS-1:0] client_y,
  input  logic [3*NUM_CLIENTS-1:0] client_colour,
  output logic [7:0]               vga_x,
  output logic [6:0]               vga_y,
  output logic [2:0]               vga_colour,
  output logic                     vga_plot,
  output logic                     frame_busy,
  output logic [15:0]              frame_count,
  output logic                     overrun
);

  localparam int DIV_W  = (FRAME_DIV > 1)   ? $clog2(FRAME_DIV)   : 1;
  localparam int SLOT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1)  ? $clog2(GAP_CYCLES)  : 1;
  localparam int IDX_W  = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam logic [NUM_CLIENTS-1:0] GRANT0 = NUM_CLIENTS'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SLOT = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  logic [DIV_W-1:0]       div_cnt_r;
  logic                   tick_s;
  state_t                 state_r, state_nx_s;
  logic [IDX_W-1:0]       idx_r, idx_nx_s;
  logic [SLOT_W-1:0]      slot_cnt_r, slot_cnt_nx_s;
  logic [GAP_W-1:0]       gap_cnt_r, gap_cnt_nx_s;
  logic [NUM_CLIENTS-1:0] enable_nx_s, client_enable_r;
  logic                   busy_nx_s, count_inc_s, overrun_set_s;
  logic                   frame_busy_r, overrun_r;
  logic [15:0]            frame_count_r;
  logic [7:0]             sel_x_s, s1_x_r, vga_x_r;
  logic [6:0]             sel_y_s, s1_y_r, vga_y_r;
  logic [2:0]             sel_colour_s, vga_colour_r;
  logic [IDX_W-1:0]       s1_idx_r;
  logic                   s1_en_r, vga_plot_r;

  assign tick_s = (div_cnt_r == DIV_W'(FRAME_DIV - 1));

  // Free-running frame tick divider
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      div_cnt_r <= '0;
    end else if (tick_s) begin
      div_cnt_r <= '0;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

  // FSM state and slot/gap/client counters
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r    <= ST_IDLE;
      idx_r      <= '0;
      slot_cnt_r <= '0;
      gap_cnt_r  <= '0;
    end else begin
      state_r    <= state_nx_s;
      idx_r      <= idx_nx_s;
      slot_cnt_r <= slot_cnt_nx_s;
      gap_cnt_r  <= gap_cnt_nx_s;
    end
  end

  // Next-state and counter sequencing
  always_comb begin
    state_nx_s    = state_r;
    idx_nx_s      = idx_r;
    slot_cnt_nx_s = slot_cnt_r;
    gap_cnt_nx_s  = gap_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (tick_s && !pause && !frame_busy_r) begin
          state_nx_s    = ST_SLOT;
          idx_nx_s      = '0;
          slot_cnt_nx_s = '0;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SLOT: begin
        if (slot_cnt_r == SLOT_W'(SLOT_CYCLES - 1)) begin
          state_nx_s   = ST_GAP;
          gap_cnt_nx_s = '0;
        end else begin
          slot_cnt_nx_s = slot_cnt_r + SLOT_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_W'(GAP_CYCLES - 1)) begin
          if (idx_r == IDX_W'(NUM_CLIENTS - 1)) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s    = ST_SLOT;
            idx_nx_s      = idx_r + IDX_W'(1);
            slot_cnt_nx_s = '0;
          end
        end else begin
          gap_cnt_nx_s = gap_cnt_r + GAP_W'(1);
        end
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Output decode from the next state so the registered grant lines up with SLOT
  always_comb begin
    enable_nx_s = '0;
    busy_nx_s   = 1'b0;
    count_inc_s = 1'b0;
    case (state_nx_s)
      ST_IDLE: busy_nx_s = 1'b0;
      ST_SLOT: begin
        enable_nx_s = GRANT0 << idx_nx_s;
        busy_nx_s   = 1'b1;
      end
      ST_GAP:  busy_nx_s = 1'b1;
      ST_DONE: begin
        busy_nx_s   = 1'b1;
        count_inc_s = 1'b1;
      end
      default: busy_nx_s = 1'b0;
    endcase
  end

  assign overrun_set_s = tick_s && frame_busy_r;

  // Registered control outputs; overrun is sticky until reset
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      client_enable_r <= '0;
      frame_busy_r    <= 1'b0;
      frame_count_r   <= 16'd0;
      overrun_r       <= 1'b0;
    end else begin
      client_enable_r <= enable_nx_s;
      frame_busy_r    <= busy_nx_s;
      frame_count_r   <= count_inc_s ? (frame_count_r + 16'd1) : frame_count_r;
      overrun_r       <= overrun_r | overrun_set_s;
    end
  end

  // Client select: x/y by current client, colour by stage-1 client (colour lags x/y)
  always_comb begin
    sel_x_s      = 8'd0;
    sel_y_s      = 7'd0;
    sel_colour_s = 3'd0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      sel_x_s      = (idx_r == IDX_W'(k))    ? client_x[8*k +: 8]      : sel_x_s;
      sel_y_s      = (idx_r == IDX_W'(k))    ? client_y[7*k +: 7]      : sel_y_s;
      sel_colour_s = (s1_idx_r == IDX_W'(k)) ? client_colour[3*k +: 3] : sel_colour_s;
    end
  end

  // Pixel pipeline; VGA coordinates hold their last value outside a plot window
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_x_r       <= 8'd0;
      s1_y_r       <= 7'd0;
      s1_idx_r     <= '0;
      s1_en_r      <= 1'b0;
      vga_x_r      <= 8'd0;
      vga_y_r      <= 7'd0;
      vga_colour_r <= 3'd0;
      vga_plot_r   <= 1'b0;
    end else begin
      s1_x_r     <= sel_x_s;
      s1_y_r     <= sel_y_s;
      s1_idx_r   <= idx_r;
      s1_en_r    <= |client_enable_r;
      vga_plot_r <= s1_en_r;
      if (s1_en_r) begin
        vga_x_r      <= s1_x_r;
        vga_y_r      <= s1_y_r;
        vga_colour_r <= sel_colour_s;
      end
    end
  end

  assign client_enable = client_enable_r;
  assign frame_busy    = frame_busy_r;
  assign frame_count   = frame_count_r;
  assign overrun       = overrun_r;
  assign vga_x         = vga_x_r;
  assign vga_y         = vga_y_r;
  assign vga_colour    = vga_colour_r;
  assign vga_plot      = vga_plot_r;

endmodule

// File: tb/tb_draw_scheduler.sv
// Self-checking bench for draw_scheduler: sprite client models feed a pixel
// scoreboard; per-scenario tasks check frame timing, pause, reset and overrun.
module tb_draw_scheduler;

  localparam int NC        = 3;
  localparam int SC        = 128;
  localparam int GC        = 2;
  localparam int FD        = 1000;
  localparam int FD_OV     = 300;
  localparam int PERIOD    = SC + GC;
  localparam int FRAME_LEN = NC * PERIOD + 1;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic            resetn, resetn_ov, pause;
  logic [NC-1:0]   client_enable;
  logic [8*NC-1:0] client_x;
  logic [7*NC-1:0] client_y;
  logic [3*NC-1:0] client_colour;
  logic [7:0]      vga_x;
  logic [6:0]      vga_y;
  logic [2:0]      vga_colour;
  logic            vga_plot, frame_busy, overrun;
  logic [15:0]     frame_count;

  logic [NC-1:0]   en_ov;
  logic [7:0]      vx_ov;
  logic [6:0]      vy_ov;
  logic [2:0]      vc_ov;
  logic            plot_ov, busy_ov, ovr_ov, pause_ov;
  logic [15:0]     fc_ov;
  logic [8*NC-1:0] zx_ov;
  logic [7*NC-1:0] zy_ov;
  logic [3*NC-1:0] zc_ov;

  draw_scheduler #(.NUM_CLIENTS(NC), .SLOT_CYCLES(SC), .FRAME_DIV(FD), .GAP_CYCLES(GC)) dut (
    .clock(clock), .resetn(resetn), .pause(pause), .client_enable(client_enable),
    .client_x(client_x), .client_y(client_y), .client_colour(client_colour),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .frame_busy(frame_busy), .frame_count(frame_count), .overrun(overrun)
  );

  draw_scheduler #(.NUM_CLIENTS(NC), .SLOT_CYCLES(SC), .FRAME_DIV(FD_OV), .GAP_CYCLES(GC)) dut_ov (
    .clock(clock), .resetn(resetn_ov), .pause(pause_ov), .client_enable(en_ov),
    .client_x(zx_ov), .client_y(zy_ov), .client_colour(zc_ov),
    .vga_x(vx_ov), .vga_y(vy_ov), .vga_colour(vc_ov), .vga_plot(plot_ov),
    .frame_busy(busy_ov), .frame_count(fc_ov), .overrun(ovr_ov)
  );

  // Sprite client models: x = counter + 50k, y = x + 1, colour registered from x[2:0]^k
  logic [6:0] ccnt [NC];
  logic [2:0] ccol [NC];

  always_comb begin
    logic [7:0] tx;
    tx = 8'd0;
    client_x = '0;
    client_y = '0;
    client_colour = '0;
    for (int k = 0; k < NC; k++) begin
      tx = {1'b0, ccnt[k]} + 8'(k * 50);
      client_x[8*k +: 8] = tx;
      client_y[7*k +: 7] = tx[6:0] + 7'd1;
      client_colour[3*k +: 3] = ccol[k];
    end
  end

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < NC; k++) begin
        ccnt[k] <= 7'd0;
        ccol[k] <= 3'd0;
      end
    end else begin
      for (int k = 0; k < NC; k++) begin
        if (client_enable[k]) ccnt[k] <= ccnt[k] + 7'd1;
        ccol[k] <= client_x[8*k +: 3] ^ 3'(k);
      end
    end
  end

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  c;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int plots  = 0;
  int cyc    = 0;
  int rc     = 0;

  // Scoreboard: push expected pixel when a client is enabled, pop when vga_plot fires
  task automatic monitor();
    exp_t e;
    if (resetn) begin
      for (int k = 0; k < NC; k++) begin
        if (client_enable[k]) begin
          e.cyc = 32'(cyc + 2);
          e.x   = client_x[8*k +: 8];
          e.y   = client_y[7*k +: 7];
          e.c   = client_x[8*k +: 3] ^ 3'(k);
          sb.push_back(e);
        end
      end
      if (vga_plot) begin
        plots++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_plot: plot at cycle %0d x %0d y %0d, required no plot", cyc, vga_x, vga_y);
        end else begin
          e = sb.pop_front();
          if (e.cyc !== 32'(cyc) || vga_x !== e.x || vga_y !== e.y || vga_colour !== e.c) begin
            errors++;
            $display("FAIL sb_pixel: cyc %0d x %0d y %0d col %0d, required cyc %0d x %0d y %0d col %0d",
                     cyc, vga_x, vga_y, vga_colour, e.cyc, e.x, e.y, e.c);
          end
        end
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clock);
      rc++;
      cyc++;
      monitor();
    end
  endtask

  function automatic logic [39:0] main_outs();
    main_outs = {client_enable, vga_x, vga_y, vga_colour, vga_plot, frame_busy, frame_count, overrun};
  endfunction

  // Frame timing checker from the current cycle through the end of a frame starting at 'start'
  task automatic check_frame(input int start, input logic [15:0] fc0, input int pause_at, input string tag);
    int rel, en_bad, busy_bad, fc_bad, p0, first_rel;
    logic [NC-1:0] e_en, one;
    logic e_busy;
    logic [15:0] e_fc;
    en_bad = 0; busy_bad = 0; fc_bad = 0; first_rel = -1;
    p0 = plots;
    one = 1;
    while (rc < start + FRAME_LEN) begin
      step(1);
      if (rc == pause_at) pause = 1'b1;
      rel = rc - start;
      e_en = '0;
      if (rel >= 0 && rel < NC * PERIOD && (rel % PERIOD) < SC) e_en = one << (rel / PERIOD);
      e_busy = (rel >= 0 && rel < FRAME_LEN);
      e_fc = fc0 + ((rel >= FRAME_LEN - 1) ? 16'd1 : 16'd0);
      if (client_enable !== e_en) begin
        if (en_bad == 0) first_rel = rel;
        en_bad++;
      end
      if (frame_busy !== e_busy) busy_bad++;
      if (frame_count !== e_fc) fc_bad++;
    end
    checks++;
    if (en_bad != 0) begin
      errors++;
      $display("FAIL %s_enable: %0d cycles wrong (first at rel %0d), required 0", tag, en_bad, first_rel);
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL %s_busy: %0d cycles wrong, required 0", tag, busy_bad);
    end
    checks++;
    if (fc_bad != 0) begin
      errors++;
      $display("FAIL %s_frame_count: %0d cycles wrong, final %0d, required final %0d", tag, fc_bad, frame_count, fc0 + 16'd1);
    end
    checks++;
    if (plots - p0 != NC * SC) begin
      errors++;
      $display("FAIL %s_plot_count: got %0d, required %0d", tag, plots - p0, NC * SC);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_sb_drain: %0d pixels never plotted, required 0", tag, sb.size());
    end
  endtask

  task automatic test_reset();
    int bad;
    resetn = 1'b0;
    step(5);
    checks++;
    if (main_outs() !== 40'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0", main_outs());
    end
    resetn = 1'b1;
    sb.delete();
    rc = 0;
    bad = 0;
    for (int c = 1; c <= FD - 1; c++) begin
      step(1);
      if (main_outs() !== 40'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_outputs: %0d nonzero cycles, required 0", bad);
    end
  endtask

  task automatic test_full_frame();
    check_frame(FD, 16'd0, -1, "frame");
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL frame_overrun: got %0b, required 0", overrun);
    end
  endtask

  task automatic test_pause();
    int bad;
    check_frame(2 * FD, 16'd1, 2 * FD + PERIOD + 10, "pause_frame");
    bad = 0;
    while (rc < 3 * FD + 100) begin
      step(1);
      if (client_enable !== '0 || frame_busy !== 1'b0 || frame_count !== 16'd2) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL paused_idle: %0d active cycles, required 0", bad);
    end
    pause = 1'b0;
    check_frame(4 * FD, 16'd2, -1, "resume");
  endtask

  task automatic test_async_reset();
    step(5 * FD + 50 - rc);
    checks++;
    if (client_enable !== 3'b001 || vga_plot !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_active: enable %b plot %0b, required 001 1", client_enable, vga_plot);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (client_enable !== 3'b000 || vga_plot !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_clear: enable %b plot %0b, required 000 0", client_enable, vga_plot);
    end
    checks++;
    if (frame_count !== 16'd0) begin
      errors++;
      $display("FAIL async_reset_count: got %0d, required 0", frame_count);
    end
    sb.delete();
    step(1);
    resetn = 1'b1;
    rc = 0;
    sb.delete();
    check_frame(FD, 16'd0, -1, "restart");
  endtask

  task automatic test_overrun();
    int busy_bad, ov_bad, fc_bad;
    logic e_busy, e_ov;
    logic [15:0] e_fc;
    busy_bad = 0; ov_bad = 0; fc_bad = 0;
    resetn_ov = 1'b0;
    step(2);
    resetn_ov = 1'b1;
    for (int t = 1; t <= 1300; t++) begin
      step(1);
      e_busy = (t >= 300 && t <= 690) || (t >= 900 && t <= 1290);
      e_ov   = (t >= 600);
      e_fc   = (t >= 1290) ? 16'd2 : ((t >= 690) ? 16'd1 : 16'd0);
      if (busy_ov !== e_busy) busy_bad++;
      if (ovr_ov !== e_ov) ov_bad++;
      if (fc_ov !== e_fc) fc_bad++;
      if (t == 300 || t == 900) begin
        checks++;
        if (en_ov !== 3'b001) begin
          errors++;
          $display("FAIL ov_frame_start: t %0d enable %b, required 001", t, en_ov);
        end
      end
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL ov_busy: %0d cycles wrong, required 0", busy_bad);
    end
    checks++;
    if (ov_bad != 0) begin
      errors++;
      $display("FAIL ov_sticky: %0d cycles wrong, final %0b, required final 1", ov_bad, ovr_ov);
    end
    checks++;
    if (fc_bad != 0) begin
      errors++;
      $display("FAIL ov_frame_count: %0d cycles wrong, final %0d, required final 2", fc_bad, fc_ov);
    end
  endtask

  initial begin
    resetn    = 1'b0;
    resetn_ov = 1'b0;
    pause     = 1'b0;
    pause_ov  = 1'b0;
    zx_ov     = '0;
    zy_ov     = '0;
    zc_ov     = '0;
    test_reset();
    test_full_frame();
    test_pause();
    test_async_reset();
    test_overrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
